// File: rtl/nonce_search_if.sv
// nonce_search_if: job/result channel between the nonce search controller and
// the SHA-256d hash core.
//   job_valid/job_ready/job_nonce : one nonce offered to the core (valid/ready)
//   res_valid/res_hash            : single-cycle result for the outstanding job
// master = search controller, slave = hash core.
interface nonce_search_if #(
    parameter int NONCE_W = 32,
    parameter int HASH_W  = 256
);
    logic               job_valid;
    logic               job_ready;
    logic [NONCE_W-1:0] job_nonce;
    logic               res_valid;
    logic [HASH_W-1:0]  res_hash;

    modport master (
        output job_valid,
        output job_nonce,
        input  job_ready,
        input  res_valid,
        input  res_hash
    );

    modport slave (
        input  job_valid,
        input  job_nonce,
        output job_ready,
        output res_valid,
        output res_hash
    );
endinterface

// File: rtl/nonce_search_ctrl.sv
// nonce_search_ctrl: walks the nonce generator through the 32-bit space, hands
// one nonce at a time to the hash core and compares each returned hash against
// the difficulty target latched at start. Stops on the first hash strictly
// below the target (found) or after the all-ones nonce loses (exhausted).
// Ports:
//   clk, rst                 : clock, async active-high reset
//   start, abort             : single-cycle control pulses from mining control
//   target                   : difficulty target, sampled on an accepted start
//   gen_nonce, gen_overflow  : nonce generator value / all-ones flag
//   gen_restart, gen_enable  : generator clear / increment
//   job_if                   : job and result channel to the hash core
//   busy, found, exhausted   : search status
//   found_nonce              : winning nonce, valid while found
//   attempts                 : results compared in this search (saturating)
module nonce_search_ctrl #(
    parameter int NONCE_W = 32,
    parameter int HASH_W  = 256
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [HASH_W-1:0]  target,
    input  logic [NONCE_W-1:0] gen_nonce,
    input  logic               gen_overflow,
    output logic               gen_restart,
    output logic               gen_enable,
    nonce_search_if.master     job_if,
    output logic               busy,
    output logic               found,
    output logic               exhausted,
    output logic [NONCE_W-1:0] found_nonce,
    output logic [NONCE_W:0]   attempts
);
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RESTART   = 3'd1,
        S_ISSUE     = 3'd2,
        S_WAIT      = 3'd3,
        S_DRAIN     = 3'd4,
        S_FOUND     = 3'd5,
        S_EXHAUSTED = 3'd6
    } state_t;

    // attempts stops at 2^NONCE_W: every nonce tried exactly once
    localparam logic [NONCE_W:0] ATT_MAX = {1'b1, {NONCE_W{1'b0}}};
    localparam logic [NONCE_W:0] ATT_ONE = {{NONCE_W{1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic [HASH_W-1:0]  target_q, target_d;
    logic [NONCE_W-1:0] issued_q, issued_d;
    logic               last_q, last_d;
    logic [NONCE_W-1:0] found_nonce_q, found_nonce_d;
    logic [NONCE_W:0]   attempts_q, attempts_d;
    logic               busy_q, busy_d;
    logic               found_q, found_d;
    logic               exhausted_q, exhausted_d;

    // Next-state, datapath updates and the combinational generator/job outputs.
    always_comb begin
        state_d          = state_q;
        target_d         = target_q;
        issued_d         = issued_q;
        last_d           = last_q;
        found_nonce_d    = found_nonce_q;
        attempts_d       = attempts_q;
        gen_restart      = 1'b0;
        gen_enable       = 1'b0;
        job_if.job_valid = 1'b0;
        job_if.job_nonce = '0;
        case (state_q)
            S_IDLE, S_FOUND, S_EXHAUSTED: begin
                // abort takes priority over start even though it is a no-op here
                if (start && !abort) begin
                    target_d      = target;
                    attempts_d    = '0;
                    found_nonce_d = '0;
                    state_d       = S_RESTART;
                end else begin
                    state_d = state_q;
                end
            end
            S_RESTART: begin
                gen_restart = 1'b1;
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                job_if.job_valid = 1'b1;
                job_if.job_nonce = gen_nonce;
                if (abort) begin
                    state_d = S_IDLE;
                end else if (job_if.job_ready) begin
                    issued_d   = gen_nonce;
                    last_d     = gen_overflow;
                    // hold the generator at all-ones so it never wraps to 0
                    gen_enable = !gen_overflow;
                    state_d    = S_WAIT;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_WAIT: begin
                if (abort) begin
                    // a result coinciding with abort is dropped; nothing left to drain
                    if (job_if.res_valid) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end else if (job_if.res_valid) begin
                    if (attempts_q != ATT_MAX) begin
                        attempts_d = attempts_q + ATT_ONE;
                    end else begin
                        attempts_d = attempts_q;
                    end
                    if (job_if.res_hash < target_q) begin
                        found_nonce_d = issued_q;
                        state_d       = S_FOUND;
                    end else if (last_q) begin
                        state_d = S_EXHAUSTED;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_DRAIN: begin
                if (job_if.res_valid) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d      = (state_d == S_RESTART) || (state_d == S_ISSUE) ||
                      (state_d == S_WAIT)    || (state_d == S_DRAIN);
        found_d     = (state_d == S_FOUND);
        exhausted_d = (state_d == S_EXHAUSTED);
    end

    // State, latched job context and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            target_q      <= '0;
            issued_q      <= '0;
            last_q        <= 1'b0;
            found_nonce_q <= '0;
            attempts_q    <= '0;
            busy_q        <= 1'b0;
            found_q       <= 1'b0;
            exhausted_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            target_q      <= target_d;
            issued_q      <= issued_d;
            last_q        <= last_d;
            found_nonce_q <= found_nonce_d;
            attempts_q    <= attempts_d;
            busy_q        <= busy_d;
            found_q       <= found_d;
            exhausted_q   <= exhausted_d;
        end
    end

    assign busy        = busy_q;
    assign found       = found_q;
    assign exhausted   = exhausted_q;
    assign found_nonce = found_nonce_q;
    assign attempts    = attempts_q;
endmodule

// File: tb/tb_nonce_search_ctrl.sv
// Bench for nonce_search_ctrl: models the nonce generator and the hash core,
// keeps a transaction-level reference of the search and compares every output
// on every cycle, with directed scenarios pinned by literal expectations.
`timescale 1ns/1ps
module tb_nonce_search_ctrl;
    localparam int NW = 32;
    localparam int HW = 256;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [HW-1:0] target = '0;
    logic [NW-1:0] gen_nonce = '0;
    logic          gen_overflow;
    logic          gen_restart, gen_enable, busy, found, exhausted;
    logic [NW-1:0] found_nonce;
    logic [NW:0]   attempts;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    nonce_search_if #(.NONCE_W(NW), .HASH_W(HW)) jif ();

    nonce_search_ctrl #(.NONCE_W(NW), .HASH_W(HW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .target(target),
        .gen_nonce(gen_nonce), .gen_overflow(gen_overflow),
        .gen_restart(gen_restart), .gen_enable(gen_enable), .job_if(jif),
        .busy(busy), .found(found), .exhausted(exhausted),
        .found_nonce(found_nonce), .attempts(attempts)
    );

    always #5 clk = ~clk;

    // ---------------- nonce generator (restart loads 'preload', normally 0)
    logic [NW-1:0] preload = '0;
    int n_restart = 0;
    int n_enable  = 0;
    assign gen_overflow = &gen_nonce;
    always @(posedge clk) begin
        if (gen_restart) gen_nonce <= preload;
        else if (gen_enable) gen_nonce <= gen_nonce + 32'd1;
        if (gen_restart) n_restart <= n_restart + 1;
        if (gen_enable)  n_enable  <= n_enable + 1;
    end

    // ---------------- reference model of one search
    bit            m_run = 0, m_rp = 0, m_out = 0, m_drn = 0, m_won = 0, m_exh = 0, m_il = 0;
    longint        m_cnt = 0;
    logic [NW-1:0] m_fn = '0, m_in = '0;
    logic [HW-1:0] m_tgt = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_run <= 0; m_rp <= 0; m_out <= 0; m_drn <= 0; m_won <= 0; m_exh <= 0;
            m_il <= 0; m_cnt <= 0; m_fn <= '0; m_in <= '0; m_tgt <= '0;
        end else if (m_drn) begin
            if (jif.res_valid) m_drn <= 0;
        end else if (!m_run) begin
            if (start && !abort) begin
                m_run <= 1; m_rp <= 1; m_out <= 0; m_won <= 0; m_exh <= 0;
                m_cnt <= 0; m_fn <= '0; m_tgt <= target;
            end
        end else if (m_rp) begin
            if (abort) m_run <= 0; else m_rp <= 0;
        end else if (!m_out) begin
            if (abort) m_run <= 0;
            else if (jif.job_ready) begin
                m_out <= 1; m_in <= gen_nonce; m_il <= (gen_nonce == 32'hFFFF_FFFF);
            end
        end else if (abort) begin
            m_run <= 0; m_out <= 0; m_drn <= !jif.res_valid;
        end else if (jif.res_valid) begin
            m_out <= 0;
            if (m_cnt < 64'h1_0000_0000) m_cnt <= m_cnt + 1;
            if (jif.res_hash < m_tgt) begin m_won <= 1; m_fn <= m_in; m_run <= 0; end
            else if (m_il) begin m_exh <= 1; m_run <= 0; end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare against the model
    bit e_jv;
    always @(negedge clk) begin
        #2;
        if (chk_en && !rst) begin
            e_jv = m_run && !m_rp && !m_out;
            chk("gen_restart", 64'(gen_restart), 64'(m_run && m_rp));
            chk("job_valid",   64'(jif.job_valid), 64'(e_jv));
            chk("job_nonce",   64'(jif.job_nonce), e_jv ? 64'(gen_nonce) : 64'd0);
            chk("gen_enable",  64'(gen_enable),
                64'(e_jv && jif.job_ready && !abort && (gen_nonce != 32'hFFFF_FFFF)));
            chk("busy",        64'(busy), 64'(m_run || m_drn));
            chk("found",       64'(found), 64'(m_won));
            chk("exhausted",   64'(exhausted), 64'(m_exh));
            chk("found_nonce", 64'(found_nonce), 64'(m_fn));
            chk("attempts",    64'(attempts), 64'(m_cnt));
        end
    end

    // ---------------- hash core and stimulus
    bit            core_pend = 0, core_hold = 0, core_go = 0;
    int            core_dly = 0, lat_max = 1;
    logic [NW-1:0] core_nonce = '0;
    int            hash_mode = 0;
    logic [NW-1:0] win_nonce = '0;
    int            ready_mode = 0, stall_left = 0;
    logic [NW-1:0] stall_nonce = '0;
    logic [NW-1:0] issued[$];
    int            seen_n2 = 0;
    int            r0, e0;

    function automatic logic [HW-1:0] hash_for(input logic [NW-1:0] n);
        logic [HW-1:0] h;
        int r;
        r = $urandom_range(0, 7);
        case (hash_mode)
            0: h = '1;
            1: h = (n == win_nonce) ? 256'h0FFF : 256'hFFFF;
            2: begin
                if (r == 0)      h = m_tgt - 256'd1;
                else if (r == 1) h = m_tgt;
                else             h = m_tgt + 256'($urandom) + 256'd1;
            end
            4: h = (n == win_nonce) ? m_tgt - 256'd1 : m_tgt;
            default: h = '0;
        endcase
        return h;
    endfunction

    // Called at a falling edge; returns at the next falling edge with new core/ready inputs.
    task automatic cycle();
        #4;
        if (jif.job_valid && jif.job_ready && !abort) begin
            core_pend  = 1;
            core_nonce = jif.job_nonce;
            core_dly   = $urandom_range(0, lat_max - 1);
            issued.push_back(jif.job_nonce);
        end
        if (jif.job_valid && jif.job_nonce == 32'd2) seen_n2++;
        @(negedge clk);
        start = 0;
        abort = 0;
        jif.res_valid = 0;
        if (core_pend) begin
            if (core_hold ? core_go : (core_dly == 0)) begin
                jif.res_valid = 1;
                jif.res_hash  = hash_for(core_nonce);
                core_pend = 0;
                core_go   = 0;
            end else if (!core_hold) begin
                core_dly--;
            end
        end
        case (ready_mode)
            0: jif.job_ready = 1;
            1: jif.job_ready = ($urandom_range(0, 2) != 0);
            2: begin
                if (stall_left > 0 && jif.job_valid && jif.job_nonce == stall_nonce) begin
                    jif.job_ready = 0;
                    stall_left--;
                end else begin
                    jif.job_ready = 1;
                end
            end
            default: jif.job_ready = 0;
        endcase
    endtask

    task automatic run_search(input int budget);
        int k = 0;
        r0 = n_restart;
        e0 = n_enable;
        issued.delete();
        start = 1;
        cycle();
        while (!(found || exhausted) && k < budget) begin
            cycle();
            k++;
        end
        if (k >= budget) begin
            tests++; fails++;
            $display("FAIL search_timeout: no found/exhausted within %0d cycles", budget);
        end
    endtask

    initial begin
        jif.job_ready = 1;
        jif.res_valid = 0;
        jif.res_hash  = '0;
        repeat (3) @(negedge clk);
        rst = 0;
        chk_en = 1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_found", 64'(found), 64'd0);
        chk("rst_exh", 64'(exhausted), 64'd0);
        chk("rst_attempts", 64'(attempts), 64'd0);
        chk("rst_job_valid", 64'(jif.job_valid), 64'd0);

        // Immediate win on the first job.
        hash_mode = 3; target = '1;
        run_search(50);
        chk("t1_found", 64'(found), 64'd1);
        chk("t1_nonce", 64'(found_nonce), 64'd0);
        chk("t1_attempts", 64'(attempts), 64'd1);
        chk("t1_restarts", 64'(n_restart - r0), 64'd1);
        chk("t1_enables", 64'(n_enable - e0), 64'd1);

        // Win at nonce 5 against target 0x1000.
        hash_mode = 1; win_nonce = 32'd5; target = 256'h1000;
        run_search(100);
        chk("t2_nonce", 64'(found_nonce), 64'd5);
        chk("t2_attempts", 64'(attempts), 64'd6);
        chk("t2_jobs", 64'(issued.size()), 64'd6);
        for (int i = 0; i < issued.size(); i++) chk("t2_seq", 64'(issued[i]), 64'(i));

        // Hash equal to target loses; the next one (target-1) wins.
        hash_mode = 4; win_nonce = 32'd1;
        run_search(100);
        chk("t_eq_nonce", 64'(found_nonce), 64'd1);
        chk("t_eq_attempts", 64'(attempts), 64'd2);

        // Core stalls 3 cycles on nonce 2.
        hash_mode = 1; win_nonce = 32'd3; ready_mode = 2; stall_nonce = 32'd2; stall_left = 3;
        seen_n2 = 0;
        run_search(100);
        chk("t3_valid_cycles_n2", 64'(seen_n2), 64'd4);
        chk("t3_nonce", 64'(found_nonce), 64'd3);
        chk("t3_enables", 64'(n_enable - e0), 64'd4);
        ready_mode = 0;

        // Exhaustion from a generator preloaded near the top.
        hash_mode = 0; preload = 32'hFFFF_FFFE;
        run_search(100);
        chk("t4_exhausted", 64'(exhausted), 64'd1);
        chk("t4_found", 64'(found), 64'd0);
        chk("t4_attempts", 64'(attempts), 64'd2);
        chk("t4_gen_nonce", 64'(gen_nonce), 64'hFFFF_FFFF);
        chk("t4_enables", 64'(n_enable - e0), 64'd1);
        chk("t4_jobs", 64'(issued.size()), 64'd2);
        if (issued.size() == 2) begin
            chk("t4_job0", 64'(issued[0]), 64'hFFFF_FFFE);
            chk("t4_job1", 64'(issued[1]), 64'hFFFF_FFFF);
        end
        preload = '0;

        // Abort while a job is outstanding; the late winning result is drained.
        hash_mode = 3; core_hold = 1; target = 256'h1000;
        start = 1;
        cycle();
        for (int k = 0; k < 20 && !core_pend; k++) cycle();
        chk("t5_pending", 64'(core_pend), 64'd1);
        abort = 1;
        cycle();
        core_go = 1;
        cycle();
        chk("t5_drain_busy", 64'(busy), 64'd1);
        chk("t5_res_seen", 64'(jif.res_valid), 64'd1);
        cycle();
        chk("t5_idle", 64'(busy), 64'd0);
        chk("t5_found", 64'(found), 64'd0);
        chk("t5_attempts", 64'(attempts), 64'd0);
        core_hold = 0;
        hash_mode = 1; win_nonce = 32'd0;
        run_search(50);
        chk("t5_restart_nonce", 64'(found_nonce), 64'd0);
        chk("t5_restart_attempts", 64'(attempts), 64'd1);
        if (issued.size() > 0) chk("t5_first_job", 64'(issued[0]), 64'd0);

        // Async reset in ISSUE after two losing results.
        win_nonce = 32'd3;
        start = 1;
        cycle();
        for (int k = 0; k < 30 && attempts != 33'd2; k++) cycle();
        chk("t6_pre_valid", 64'(jif.job_valid), 64'd1);
        chk("t6_pre_attempts", 64'(attempts), 64'd2);
        #1 rst = 1;
        #1;
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_job_valid", 64'(jif.job_valid), 64'd0);
        chk("t6_attempts", 64'(attempts), 64'd0);
        @(negedge clk);
        rst = 0;
        core_pend = 0;
        jif.res_valid = 0;
        start = 1;
        abort = 1;
        cycle();
        chk("t6_start_abort_busy", 64'(busy), 64'd0);
        chk("t6_start_abort_restart", 64'(gen_restart), 64'd0);

        // Randomized traffic against the model.
        hash_mode = 2; ready_mode = 1; lat_max = 3;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                start = 1;
                for (int w = 0; w < 8; w++) target[w*32 +: 32] = $urandom;
                target[HW-1] = 1'b0;
                if (!(m_run || m_drn))
                    preload = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                          : 32'($urandom_range(0, 100));
            end
            if ($urandom_range(0, 29) == 0) abort = 1;
            cycle();
        end
        cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
